// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 non-restoring divider.
// State encoding and step-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/add_sub_unit.sv
// (W+1)-bit adder/subtractor for the divider partial remainder.
// Operand b is inverted by sub, and sub also supplies the carry-in.
module add_sub_unit #(
    parameter int W = 8
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    input  logic       sub,
    output logic [W:0] sum
);

    logic [W:0] b_x;
    logic [W:0] cin;

    // XOR-controlled operand and carry-in, then a plain add
    always_comb begin
        b_x = b ^ {(W + 1){sub}};
        cin = {{W{1'b0}}, sub};
        sum = a + b_x + cin;
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned radix-2 non-restoring divider.
// One quotient bit per clock, then a single remainder-fix step.
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_w(WIDTH);

    div_state_e       state;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   add_a;
    logic             sub;
    logic [WIDTH:0]   sum;

    // RUN adds/subtracts M to the shifted A; FIX adds M back to A
    always_comb begin
        a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        if (state == RUN) begin
            add_a = a_sh;
            sub   = ~a_q[WIDTH];
        end else begin
            add_a = a_q;
            sub   = 1'b0;
        end
    end

    add_sub_unit #(
        .W(WIDTH)
    ) u_add_sub (
        .a  (add_a),
        .b  (m_q),
        .sub(sub),
        .sum(sum)
    );

    // Control FSM with A/Q/M datapath registers and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            m_q         <= '0;
            q_q         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            a_q   <= '0;
                            q_q   <= dividend;
                            m_q   <= {1'b0, divisor};
                            cnt   <= CW'(WIDTH);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    a_q <= sum;
                    q_q <= {q_q[WIDTH-2:0], ~sum[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient <= q_q;
                    if (a_q[WIDTH]) begin
                        remainder <= sum[WIDTH-1:0];
                    end else begin
                        remainder <= a_q[WIDTH-1:0];
                    end
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (WIDTH=8).
// Table vectors, hand corner sequences and a random sweep vs / and %.
module tb_nonrestoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int nchk = 0;
    int nfail = 0;
    int dones = 0;
    int exp_dones = 0;

    typedef struct {
        int dd;
        int dv;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    vec_t tbl[8];

    nonrestoring_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) dones++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    // lat = rising edges after the accepting edge until done is visible.
    task automatic run_div(input int dd, input int dv,
                           output int q, output int r, output int dz,
                           output int lat, output int bcnt);
        dividend = W'(dd);
        divisor  = W'(dv);
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            bcnt += int'(busy);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp_dones++;
        chk("busy_low_at_done", int'(busy), 0);
        q  = int'(quotient);
        r  = int'(remainder);
        dz = int'(div_by_zero);
    endtask

    initial begin
        int q, r, dz, lat, bc, e, nd;
        int dd, dv, eq, er, edz, elat;

        tbl[0] = '{100,   7,  14,   2, 0, 9};
        tbl[1] = '{255,   1, 255,   0, 0, 9};
        tbl[2] = '{  5,   9,   0,   5, 0, 9};
        tbl[3] = '{255, 255,   1,   0, 0, 9};
        tbl[4] = '{ 37,   0, 255,  37, 1, 0};
        tbl[5] = '{ 40,   8,   5,   0, 0, 9};
        tbl[6] = '{  0,   5,   0,   0, 0, 9};
        tbl[7] = '{128,   2,  64,   0, 0, 9};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem", int'(remainder), 0);
        chk("rst_dz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_div(tbl[i].dd, tbl[i].dv, q, r, dz, lat, bc);
            chk($sformatf("tbl%0d_quot", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_rem", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busycyc", i), bc,
                (tbl[i].dv == 0) ? 0 : 9);
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_single_pulse", int'(done), 0);

        // 200/13 with ignored start pulses (9/3) mid-operation
        dividend = 8'd200;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (!done && e < 40) begin
            e++;
            if (e == 3 || e == 6) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        exp_dones++;
        chk("ign_lat", e, 9);
        chk("ign_quot", int'(quotient), 15);
        chk("ign_rem", int'(remainder), 5);
        run_div(9, 3, q, r, dz, lat, bc);
        chk("b2b_quot", q, 3);
        chk("b2b_rem", r, 0);
        chk("b2b_lat", lat, 9);

        // asynchronous reset in the middle of 100/7
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_quot", int'(quotient), 0);
        chk("arst_rem", int'(remainder), 0);
        chk("arst_dz", int'(div_by_zero), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            nd += int'(done);
            nd += int'(busy);
        end
        chk("arst_no_done_busy", nd, 0);
        run_div(100, 7, q, r, dz, lat, bc);
        chk("post_rst_quot", q, 14);
        chk("post_rst_rem", r, 2);
        chk("post_rst_lat", lat, 9);

        // random sweep against integer division
        for (int i = 0; i < 3000; i++) begin
            dv = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(1, 255);
            dd = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 255);
            if (dv == 0) begin
                eq = 255; er = dd; edz = 1; elat = 0;
            end else begin
                eq = dd / dv; er = dd % dv; edz = 0; elat = 9;
            end
            run_div(dd, dv, q, r, dz, lat, bc);
            chk($sformatf("rnd%0d_%0d/%0d_quot", i, dd, dv), q, eq);
            chk($sformatf("rnd%0d_%0d/%0d_rem", i, dd, dv), r, er);
            chk($sformatf("rnd%0d_dz", i), dz, edz);
            chk($sformatf("rnd%0d_lat", i), lat, elat);
            if (dv != 0) begin
                chk($sformatf("rnd%0d_recon", i), q * dv + r, dd);
                chk($sformatf("rnd%0d_rem_lt", i), int'(r < dv), 1);
            end
        end

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_count", dones, exp_dones);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
